pipelined_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the datapath's shift unit. Performs logical-left, logical-right and arithmetic-right shifts of an N-bit operand by a $clog2(N)-bit amount, with one register per shift stage. Uses a valid/ready handshake on both sides so the ALU or execute stage can stall it without losing results. Replaces the single-cycle combinational shifters where timing on wide shifts is critical.

---
 rtl/shifter_pkg.sv | 20 ++
 rtl/shift_stage.sv | 30 +++
 rtl/pipelined_shifter.sv | 118 +++++++++++
 tb/tb_pipelined_shifter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// SHIFTER_ROTATE_EN selects whether ROR rotates or acts as SRL.
package shifter_pkg;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2,
    ROR = 2'd3
  } shift_mode_t;

  // Bit-reverse: source index feeding bit i of an n-bit reversed word.
  function automatic int unsigned bit_rev_idx(
    input int unsigned i,
    input int unsigned n
  );
    return n - 1 - i;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational right-shift-by-2^K step with fill or rotate.
// Rotate input exists only when SHIFTER_ROTATE_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 0
) (
  input  logic [N-1:0] i_data,
  input  logic         i_en,
  input  logic         i_fill,
`ifdef SHIFTER_ROTATE_EN
  input  logic         i_rot,
`endif
  output logic [N-1:0] o_data
);

  localparam int S = 1 << K;

  logic [S-1:0] w_top;

  always_comb begin
    w_top = {S{i_fill}};
`ifdef SHIFTER_ROTATE_EN
    if (i_rot) w_top = i_data[S-1:0];
`endif
    o_data = i_en ? {w_top, i_data[N-1:S]} : i_data;
  end

endmodule

// File: rtl/pipelined_shifter.sv
// L-stage pipelined barrel shifter with bubble-collapsing handshake.
// SHIFTER_ROTATE_EN enables ROR; otherwise ROR decodes as SRL.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_shamt,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data
);

  localparam int L = $clog2(N);

  logic              r_v     [L];
  logic [N-1:0]      r_data  [L];
  logic [L-1:0]      r_shamt [L];
  shift_mode_t       r_mode  [L];
  logic              r_fill  [L];

  logic              w_adv   [L];
  logic [N-1:0]      w_rev_in;
  logic [N-1:0]      w_rev_out;
  logic [N-1:0]      w_data0;
  logic              w_fill0;
  shift_mode_t       w_mode0;

  for (genvar i = 0; i < N; i++) begin : g_rev
    assign w_rev_in[i]  = in_data[bit_rev_idx(i, N)];
    assign w_rev_out[i] = r_data[L-1][bit_rev_idx(i, N)];
  end

  // Left shifts run as right shifts on the reversed operand.
  always_comb begin
    w_mode0 = shift_mode_t'(in_mode);
    w_data0 = in_data;
    w_fill0 = 1'b0;
    unique case (1'b1)
      (w_mode0 == SLL): w_data0 = w_rev_in;
      (w_mode0 == SRA): w_fill0 = in_data[N-1];
      default: ;
    endcase
  end

  // A stage may load if it or any stage below it holds a bubble.
  always_comb begin
    for (int k = 0; k < L; k++) begin
      w_adv[k] = out_ready;
      for (int j = k; j < L; j++) begin
        if (!r_v[j]) w_adv[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic [N-1:0] w_up_data;
    logic [L-1:0] w_up_shamt;
    shift_mode_t  w_up_mode;
    logic         w_up_fill;
    logic         w_up_v;
    logic [N-1:0] w_out;

    if (k == 0) begin : g_first
      assign w_up_data  = w_data0;
      assign w_up_shamt = in_shamt;
      assign w_up_mode  = w_mode0;
      assign w_up_fill  = w_fill0;
      assign w_up_v     = in_valid;
    end else begin : g_rest
      assign w_up_data  = r_data[k-1];
      assign w_up_shamt = r_shamt[k-1];
      assign w_up_mode  = r_mode[k-1];
      assign w_up_fill  = r_fill[k-1];
      assign w_up_v     = r_v[k-1];
    end

    shift_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .i_data (w_up_data),
      .i_en   (w_up_shamt[k]),
      .i_fill (w_up_fill),
`ifdef SHIFTER_ROTATE_EN
      .i_rot  (w_up_mode == ROR),
`endif
      .o_data (w_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[k]     <= 1'b0;
        r_data[k]  <= '0;
        r_shamt[k] <= '0;
        r_mode[k]  <= SLL;
        r_fill[k]  <= 1'b0;
      end else if (w_adv[k]) begin
        r_v[k]     <= w_up_v;
        r_data[k]  <= w_out;
        r_shamt[k] <= w_up_shamt;
        r_mode[k]  <= w_up_mode;
        r_fill[k]  <= w_up_fill;
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[L-1];
  assign out_data  = (r_mode[L-1] == SLL) ? w_rev_out : r_data[L-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (N=32), directed + random.
// Expected results come from a plain-arithmetic shift model.
module tb_pipelined_shifter;

  localparam int N = 32;
  localparam int L = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [L-1:0]  in_shamt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  typedef struct {
    logic [N-1:0] exp;
    int           cyc;
    bit           lat;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_in = 0;
  int   n_out = 0;
  int   cyc = 0;

  pipelined_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] model(
    input logic [N-1:0] d, input int s, input logic [1:0] m
  );
`ifdef SHIFTER_ROTATE_EN
    logic [2*N-1:0] dd;
`endif
    case (m)
      2'd0: return d << s;
      2'd1: return d >> s;
      2'd2: return N'($signed(d) >>> s);
      default: begin
`ifdef SHIFTER_ROTATE_EN
        dd = {d, d};
        return dd[s +: N];
`else
        return d >> s;
`endif
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %h with nothing pending",
                   out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.exp);
          if (e.lat) check("latency", N'(cyc - e.cyc), N'(L));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [N-1:0] d,
                      input logic [L-1:0] s, input logic [1:0] m,
                      input logic [N-1:0] exp, input bit lat,
                      input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_shamt  = s;
    in_mode   = m;
    out_ready = ordy;
    #2;
    acc = in_valid && in_ready;
    if (acc) begin
      sb.push_back('{exp: exp, cyc: cyc, lat: lat});
      n_in++;
    end
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, $urandom, 5'($urandom), 2'($urandom), '0, 1'b0, ordy, acc);
  endtask

  task automatic send(input logic [N-1:0] d, input logic [L-1:0] s,
                      input logic [1:0] m, input logic [N-1:0] exp,
                      input bit lat);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++)
      step(1'b1, d, s, m, exp, lat, 1'b1, acc);
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0",
               sb.size());
    end
  endtask

  typedef struct {
    logic [N-1:0] d;
    logic [L-1:0] s;
    logic [1:0]   m;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic acc;
    int   i0, o0, k, nxt, first_block;
    logic [N-1:0] d;
    logic [L-1:0] s;
    logic [1:0]   m;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_shamt = '0;
    in_mode = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", N'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", N'(in_ready), N'(1));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", N'(in_ready), N'(1));
    check("post_rst_out_valid", N'(out_valid), '0);

    vecs.push_back('{32'h8000_0000, 5'd31, 2'd1, 32'h0000_0001});
    vecs.push_back('{32'h8000_0000, 5'd4,  2'd2, 32'hF800_0000});
    vecs.push_back('{32'h7000_0000, 5'd4,  2'd2, 32'h0700_0000});
    vecs.push_back('{32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'd0, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'd2, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'd3, 32'hDEAD_BEEF});
`ifdef SHIFTER_ROTATE_EN
    vecs.push_back('{32'h0000_00F1, 5'd4, 2'd3, 32'h1000_000F});
`else
    vecs.push_back('{32'h0000_00F1, 5'd4, 2'd3, 32'h0000_000F});
`endif
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].s, vecs[i].m, vecs[i].exp, 1'b1);
      drain();
    end

    // Stall/order: out_ready low in cycles 3..10 of the burst.
    o0 = n_out;
    nxt = 1;
    k = 1;
    first_block = -1;
    while (nxt <= 8 && k < 60) begin
      step(1'b1, N'(nxt), 5'd1, 2'd0, N'(nxt * 2), 1'b0,
           !(k >= 3 && k <= 10), acc);
      if (acc) nxt++;
      else if (first_block < 0) first_block = nxt - 1;
      k++;
    end
    check("stall_accepted", N'(first_block), N'(5));
    drain();
    check("stall_out_count", N'(n_out - o0), N'(8));

    // Random stress.
    i0 = n_in;
    o0 = n_out;
    for (int c = 0; c < 60000 && (n_in - i0) < 10000; c++) begin
      d = $urandom;
      s = 5'($urandom);
      m = 2'($urandom);
      step($urandom_range(0, 3) != 0, d, s, m, model(d, int'(s), m),
           1'b0, $urandom_range(0, 3) != 0, acc);
    end
    drain();
    check("stress_in_count", N'(n_in - i0), N'(10000));
    check("stress_handshakes", N'(n_out - o0), N'(n_in - i0));

    // Reset with operands in flight.
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      step(1'b1, d, 5'd3, 2'd1, model(d, 3, 2'd1), 1'b0, 1'b0, acc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", N'(out_valid), '0);
    check("midrst_out_data", out_data, '0);
    check("midrst_in_ready", N'(in_ready), N'(1));
    sb.delete();
    o0 = n_out;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("no_stale_output", N'(n_out - o0), '0);
    send(32'h0000_0F00, 5'd8, 2'd1, 32'h0000_000F, 1'b1);
    drain();
    check("post_rst_out_count", N'(n_out - o0), N'(1));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
